// File: rtl/flag_unit.sv
// Condition-flag producer: computes NZCV from ALU ops and holds the flags register.
// Optional saved-flag LIFO, built when FLAG_STACK_EN is defined.
package flag_pkg;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;
endpackage

module flag_unit
   import flag_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   input  logic             set_flags,
   input  logic [1:0]       op_class,
   input  logic             use_carry,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] logic_result,
   input  logic             shifter_carry,
   input  flags_t           wr_flags,
   input  logic             push,
   input  logic             pop,
   output flags_t           flags,
   output logic [WIDTH-1:0] arith_result,
   output logic             stack_empty,
   output logic             stack_full,
   output logic             stack_err
);
   localparam logic [1:0] OP_LOGIC = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_WR    = 2'b11;
   localparam int MSB = WIDTH - 1;

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             pop_ok;
   logic             upd_blk;
   flags_t           top;
   flags_t           flags_nxt;
   logic             upd;

   // Sub is a + ~b + cin, so carry-out means "no borrow".
   always_comb begin
      is_sub = (op_class == OP_SUB);
      b_eff  = is_sub ? ~op_b : op_b;
      cin    = use_carry ? flags.c : is_sub;
      sum    = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      res    = sum[WIDTH-1:0];
   end

   assign upd = alu_valid && set_flags && !upd_blk;

   always_comb begin
      flags_nxt = flags;
      if (pop_ok) begin
         flags_nxt = top;
      end else if (upd) begin
         case (op_class)
            OP_LOGIC: begin
               flags_nxt.n = logic_result[MSB];
               flags_nxt.z = (logic_result == '0);
               flags_nxt.c = shifter_carry;
            end
            OP_ADD: begin
               flags_nxt.n = res[MSB];
               flags_nxt.z = (res == '0);
               flags_nxt.c = sum[WIDTH];
               flags_nxt.v = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
               flags_nxt.n = res[MSB];
               flags_nxt.z = (res == '0);
               flags_nxt.c = sum[WIDTH];
               flags_nxt.v = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
            end
            OP_WR:   flags_nxt = wr_flags;
            default: flags_nxt = flags;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags        <= '0;
         arith_result <= '0;
      end else begin
         flags <= flags_nxt;
         if (alu_valid && (op_class == OP_ADD || op_class == OP_SUB))
            arith_result <= res;
      end
   end

`ifdef FLAG_STACK_EN
   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);

   flags_t        stack [STACK_DEPTH];
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          is_empty;
   logic          is_full;
   logic          push_ok;
   logic          err_nxt;

   assign is_empty = (count == '0);
   assign is_full  = (count == FULL_CNT);
   assign push_ok  = push && !pop && !is_full;
   assign pop_ok   = pop && !push && !is_empty;
   assign err_nxt  = (push && pop) || (push && !pop && is_full) || (pop && !push && is_empty);
   // A lone pop blocks the ALU update even when it is rejected; push+pop does not.
   assign upd_blk  = pop && !push;

   always_comb begin
      count_nxt = count;
      if (push_ok)
         count_nxt = count + 1'b1;
      else if (pop_ok)
         count_nxt = count - 1'b1;
   end

   always_comb begin
      top = '0;
      for (int i = 0; i < STACK_DEPTH; i++)
         if (count == CW'(i + 1)) top = stack[i];
   end

   // Entries need no reset: the count alone decides what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++)
         if (push_ok && count == CW'(i)) stack[i] <= flags;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         stack_empty <= 1'b1;
         stack_full  <= 1'b0;
         stack_err   <= 1'b0;
      end else begin
         count       <= count_nxt;
         stack_empty <= (count_nxt == '0);
         stack_full  <= (count_nxt == FULL_CNT);
         stack_err   <= err_nxt;
      end
   end
`else
   logic unused_stack;

   assign unused_stack = push ^ pop;
   assign pop_ok       = 1'b0;
   assign upd_blk      = 1'b0;
   assign top          = '0;
   assign stack_empty  = 1'b1;
   assign stack_full   = 1'b0;
   assign stack_err    = 1'b0;
`endif
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit; flags compared as 4-bit NZCV.
module tb_flag_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, set_flags, use_carry, shifter_carry, push, pop;
   logic [1:0]  op_class;
   logic [31:0] op_a, op_b, logic_result;
   logic [3:0]  wr_flags;
   logic [3:0]  flags;
   logic [31:0] arith_result;
   logic        stack_empty, stack_full, stack_err;

   int errors = 0;
   int checks = 0;

   flag_unit #(.WIDTH(32), .STACK_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .set_flags(set_flags),
      .op_class(op_class), .use_carry(use_carry), .op_a(op_a), .op_b(op_b),
      .logic_result(logic_result), .shifter_carry(shifter_carry), .wr_flags(wr_flags),
      .push(push), .pop(pop), .flags(flags), .arith_result(arith_result),
      .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      alu_valid = 0; set_flags = 0; use_carry = 0; shifter_carry = 0;
      push = 0; pop = 0; op_class = 2'b00; op_a = '0; op_b = '0;
      logic_result = '0; wr_flags = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic arith(input logic [1:0] cls, input logic [31:0] a, input logic [31:0] b,
                        input logic uc, input logic sf);
      alu_valid = 1; op_class = cls; op_a = a; op_b = b; use_carry = uc; set_flags = sf;
      tick();
   endtask

   task automatic wr(input logic [3:0] v);
      alu_valid = 1; set_flags = 1; op_class = 2'b11; wr_flags = v;
      tick();
   endtask

   initial begin
      idle();
      rst_n = 0;
      #12 rst_n = 1;
      @(negedge clk);
      chk("rst_flags", {28'h0, flags}, 32'h0);
      chk("rst_arith", arith_result, 32'h0);
      chk("rst_empty", {31'h0, stack_empty}, 32'h1);
      chk("rst_full", {31'h0, stack_full}, 32'h0);
      chk("rst_err", {31'h0, stack_err}, 32'h0);

      arith(2'b01, 32'h7FFFFFFF, 32'h1, 0, 1);
      chk("add_ovf_flags", {28'h0, flags}, 32'h9);
      chk("add_ovf_res", arith_result, 32'h80000000);

      arith(2'b10, 32'd5, 32'd5, 0, 1);
      chk("sub_eq_flags", {28'h0, flags}, 32'h6);
      chk("sub_eq_res", arith_result, 32'h0);
      arith(2'b10, 32'd3, 32'd5, 0, 1);
      chk("sub_borrow_flags", {28'h0, flags}, 32'h8);
      chk("sub_borrow_res", arith_result, 32'hFFFFFFFE);

      wr(4'h2);
      arith(2'b01, 32'hFFFFFFFF, 32'h0, 1, 1);
      chk("adc_flags", {28'h0, flags}, 32'h6);
      chk("adc_res", arith_result, 32'h0);
      arith(2'b10, 32'd3, 32'd5, 0, 0);
      chk("nos_sub_flags", {28'h0, flags}, 32'h6);
      chk("nos_sub_res", arith_result, 32'hFFFFFFFE);
      arith(2'b01, 32'hFFFFFFFF, 32'h0, 1, 0);
      chk("nos_adc_flags", {28'h0, flags}, 32'h6);
      chk("nos_adc_res", arith_result, 32'h0);

      arith(2'b01, 32'd1, 32'd1, 0, 0);
      wr(4'h1);
      chk("wr_v_flags", {28'h0, flags}, 32'h1);
      chk("wr_keeps_res", arith_result, 32'h2);
      alu_valid = 1; set_flags = 1; op_class = 2'b00;
      logic_result = 32'h80000000; shifter_carry = 1;
      tick();
      chk("logic_flags", {28'h0, flags}, 32'hB);
      chk("logic_keeps_res", arith_result, 32'h2);
      wr(4'h0);
      chk("wr_zero", {28'h0, flags}, 32'h0);

      alu_valid = 0; set_flags = 1; op_class = 2'b11; wr_flags = 4'hF;
      tick();
      chk("no_valid_hold", {28'h0, flags}, 32'h0);

      arith(2'b10, 32'd5, 32'd3, 1, 1);
      chk("sbc_c0_flags", {28'h0, flags}, 32'h2);
      chk("sbc_c0_res", arith_result, 32'h1);
      arith(2'b01, 32'd1, 32'd1, 1, 1);
      chk("adc_c1_flags", {28'h0, flags}, 32'h0);
      chk("adc_c1_res", arith_result, 32'h3);
      arith(2'b01, 32'h80000000, 32'h80000000, 0, 1);
      chk("add_neg_ovf", {28'h0, flags}, 32'h7);

`ifdef FLAG_STACK_EN
      for (int k = 1; k <= 4; k++) begin
         wr(k[3:0]);
         push = 1;
         tick();
      end
      chk("full_after4", {31'h0, stack_full}, 32'h1);
      chk("notempty_after4", {31'h0, stack_empty}, 32'h0);
      wr(4'h5);
      push = 1;
      tick();
      chk("push_full_err", {31'h0, stack_err}, 32'h1);
      chk("push_full_stays", {31'h0, stack_full}, 32'h1);
      tick();
      chk("err_one_cycle", {31'h0, stack_err}, 32'h0);
      for (int k = 4; k >= 1; k--) begin
         pop = 1; alu_valid = 1; set_flags = 1; op_class = 2'b11; wr_flags = 4'hF;
         tick();
         chk("pop_lifo", {28'h0, flags}, k);
         chk("pop_no_err", {31'h0, stack_err}, 32'h0);
      end
      chk("empty_after_pops", {31'h0, stack_empty}, 32'h1);
      pop = 1; alu_valid = 1; set_flags = 1; op_class = 2'b11; wr_flags = 4'hF;
      tick();
      chk("pop_empty_err", {31'h0, stack_err}, 32'h1);
      chk("pop_empty_blocks", {28'h0, flags}, 32'h1);
      push = 1; pop = 1; alu_valid = 1; set_flags = 1; op_class = 2'b11; wr_flags = 4'h6;
      tick();
      chk("pushpop_err", {31'h0, stack_err}, 32'h1);
      chk("pushpop_cnt", {31'h0, stack_empty}, 32'h1);
      chk("pushpop_alu", {28'h0, flags}, 32'h6);
      push = 1; alu_valid = 1; set_flags = 1; op_class = 2'b11; wr_flags = 4'h9;
      tick();
      chk("push_upd_flags", {28'h0, flags}, 32'h9);
      pop = 1;
      tick();
      chk("push_upd_old", {28'h0, flags}, 32'h6);

      wr(4'hF);
      push = 1; tick();
      push = 1; tick();
      #2 rst_n = 0;
      #1;
      chk("mid_rst_flags", {28'h0, flags}, 32'h0);
      chk("mid_rst_empty", {31'h0, stack_empty}, 32'h1);
      @(negedge clk) rst_n = 1;
      pop = 1;
      tick();
      chk("rst_pop_err", {31'h0, stack_err}, 32'h1);
`else
      pop = 1; alu_valid = 1; set_flags = 1; op_class = 2'b11; wr_flags = 4'h6;
      tick();
      chk("nostack_pop_upd", {28'h0, flags}, 32'h6);
      chk("nostack_err", {31'h0, stack_err}, 32'h0);
      push = 1;
      tick();
      chk("nostack_empty", {31'h0, stack_empty}, 32'h1);
      chk("nostack_full", {31'h0, stack_full}, 32'h0);

      wr(4'hF);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_flags", {28'h0, flags}, 32'h0);
      chk("mid_rst_arith", arith_result, 32'h0);
      @(negedge clk) rst_n = 1;
`endif
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
